// File: rtl/ibex_obi_mem_responder.sv
// OBI memory responder for one Ibex bus port: word RAM with configurable grant delay and response latency.
// Optional macro IBEX_MEM_WINTG_CHECK_EN enables write-data integrity checking.
module ibex_obi_mem_responder #(
    parameter int          MemSizeWords = 4096,
    parameter logic [31:0] BaseAddr     = 32'h0010_0000,
    parameter int          GntDelay     = 0,
    parameter int          RspLatency   = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    input  logic [6:0]  wdata_intg_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic [6:0]  rdata_intg_o,
    output logic        err_o
);

    localparam int          IdxW    = $clog2(MemSizeWords);
    localparam int          CntW    = 3;
    localparam logic [32:0] EndAddr = {1'b0, BaseAddr} + 33'(4 * MemSizeWords);

    // Inverted 39/32 SECDED: parity bits of the Hsiao code, then XOR with 7'h2A.
    function automatic logic [6:0] secded_enc(input logic [31:0] d);
        logic [6:0] p;
        p[0] = ^(d & 32'h2606_BD25);
        p[1] = ^(d & 32'hDEBA_8050);
        p[2] = ^(d & 32'h413D_89AA);
        p[3] = ^(d & 32'h3123_4ED1);
        p[4] = ^(d & 32'hC2C1_323B);
        p[5] = ^(d & 32'h2DCC_624C);
        p[6] = ^(d & 32'h9850_5586);
        return p ^ 7'h2A;
    endfunction

    typedef enum logic {IDLE, STALL} state_e;

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic              gnt;

    always_comb begin
        gnt = 1'b0;
        if (GntDelay == 0) begin
            gnt = req_i;
        end else begin
            gnt = req_i && (state_q == STALL) && (cnt_q == CntW'(GntDelay));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_i && (GntDelay != 0)) begin
                        state_q <= STALL;
                        cnt_q   <= CntW'(1);
                    end
                end
                STALL: begin
                    // A dropped request is a protocol violation; recover to IDLE.
                    if (gnt || !req_i) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign gnt_o = gnt;

    logic            in_range;
    logic [IdxW-1:0] idx;
    logic            intg_ok;

    assign in_range = ({1'b0, addr_i} >= {1'b0, BaseAddr}) && ({1'b0, addr_i} < EndAddr);
    assign idx      = addr_i[2 +: IdxW];

`ifdef IBEX_MEM_WINTG_CHECK_EN
    logic [15:0] intg_err_cnt;

    assign intg_ok = (wdata_intg_i == secded_enc(wdata_i));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            intg_err_cnt <= '0;
        end else if (gnt && we_i && !intg_ok && (intg_err_cnt != 16'hFFFF)) begin
            intg_err_cnt <= intg_err_cnt + 16'd1;
        end
    end
`else
    logic unused_wdata_intg;

    assign unused_wdata_intg = ^wdata_intg_i;
    assign intg_ok           = 1'b1;
`endif

    logic [31:0] mem [MemSizeWords];
    logic        wr_en;
    logic        rsp_err;
    logic [31:0] rsp_data;

    assign wr_en    = gnt && we_i && in_range && intg_ok;
    assign rsp_err  = !in_range || (we_i && !intg_ok);
    assign rsp_data = (!we_i && in_range) ? mem[idx] : '0;

    // The array is deliberately left unreset so contents survive a mid-run reset.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int k = 0; k < 4; k++) begin
                if (be_i[k]) begin
                    mem[idx][8*k +: 8] <= wdata_i[8*k +: 8];
                end
            end
        end
    end

    logic        vld_q  [RspLatency];
    logic        err_q  [RspLatency];
    logic [31:0] data_q [RspLatency];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < RspLatency; i++) begin
                vld_q[i]  <= 1'b0;
                err_q[i]  <= 1'b0;
                data_q[i] <= '0;
            end
        end else begin
            vld_q[0]  <= gnt;
            err_q[0]  <= gnt && rsp_err;
            data_q[0] <= gnt ? rsp_data : '0;
            for (int i = 1; i < RspLatency; i++) begin
                vld_q[i]  <= vld_q[i-1];
                err_q[i]  <= err_q[i-1];
                data_q[i] <= data_q[i-1];
            end
        end
    end

    assign rvalid_o     = vld_q[RspLatency-1];
    assign err_o        = err_q[RspLatency-1];
    assign rdata_o      = data_q[RspLatency-1];
    assign rdata_intg_o = secded_enc(rdata_o);

`ifndef SYNTHESIS
    stable_while_stalled: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (req_i && !gnt_o) |=> $stable({addr_i, we_i, be_i, wdata_i}));

    req_held_until_gnt: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (req_i && !gnt_o) |=> req_i);
`endif

endmodule

// File: tb/tb_ibex_obi_mem_responder.sv
// Randomized self-checking bench for ibex_obi_mem_responder: three instances with different
// grant delays / latencies checked every cycle against a transaction-level memory model.
module tb_ibex_obi_mem_responder;

    localparam int          NumDut = 3;
    localparam int          Words  = 64;
    localparam logic [31:0] Base   = 32'h0010_0000;
    localparam int          GD [NumDut] = '{0, 3, 1};
    localparam int          RL [NumDut] = '{1, 2, 3};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n  [NumDut];
    logic        req    [NumDut];
    logic [31:0] addr   [NumDut];
    logic        we     [NumDut];
    logic [3:0]  be     [NumDut];
    logic [31:0] wdata  [NumDut];
    logic [6:0]  wintg  [NumDut];
    logic        gnt    [NumDut];
    logic        rvalid [NumDut];
    logic [31:0] rdata  [NumDut];
    logic [6:0]  rintg  [NumDut];
    logic        err    [NumDut];

    ibex_obi_mem_responder #(.MemSizeWords(Words), .BaseAddr(Base), .GntDelay(GD[0]), .RspLatency(RL[0])) dut0 (
        .clk_i(clk), .rst_ni(rst_n[0]), .req_i(req[0]), .gnt_o(gnt[0]), .addr_i(addr[0]), .we_i(we[0]),
        .be_i(be[0]), .wdata_i(wdata[0]), .wdata_intg_i(wintg[0]), .rvalid_o(rvalid[0]), .rdata_o(rdata[0]),
        .rdata_intg_o(rintg[0]), .err_o(err[0]));

    ibex_obi_mem_responder #(.MemSizeWords(Words), .BaseAddr(Base), .GntDelay(GD[1]), .RspLatency(RL[1])) dut1 (
        .clk_i(clk), .rst_ni(rst_n[1]), .req_i(req[1]), .gnt_o(gnt[1]), .addr_i(addr[1]), .we_i(we[1]),
        .be_i(be[1]), .wdata_i(wdata[1]), .wdata_intg_i(wintg[1]), .rvalid_o(rvalid[1]), .rdata_o(rdata[1]),
        .rdata_intg_o(rintg[1]), .err_o(err[1]));

    ibex_obi_mem_responder #(.MemSizeWords(Words), .BaseAddr(Base), .GntDelay(GD[2]), .RspLatency(RL[2])) dut2 (
        .clk_i(clk), .rst_ni(rst_n[2]), .req_i(req[2]), .gnt_o(gnt[2]), .addr_i(addr[2]), .we_i(we[2]),
        .be_i(be[2]), .wdata_i(wdata[2]), .wdata_intg_i(wintg[2]), .rvalid_o(rvalid[2]), .rdata_o(rdata[2]),
        .rdata_intg_o(rintg[2]), .err_o(err[2]));

    int cyc      = 0;
    int n_checks = 0;
    int n_fail   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Integrity reference: each check bit is the parity of the data bits it covers, inverted by 7'h2A.
    function automatic logic [6:0] enc(input logic [31:0] d);
        logic [31:0] masks [7];
        logic [6:0]  p;
        masks = '{32'h2606_BD25, 32'hDEBA_8050, 32'h413D_89AA, 32'h3123_4ED1,
                  32'hC2C1_323B, 32'h2DCC_624C, 32'h9850_5586};
        for (int i = 0; i < 7; i++) p[i] = ($countones(d & masks[i]) % 2) == 1;
        return p ^ 7'h2A;
    endfunction

    function automatic string nm(input string s, input int d);
        return $sformatf("d%0d_%s", d, s);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int          dut;
        int          due;
        logic        err;
        logic [31:0] data;
    } rsp_t;

    rsp_t        exp_q [$];
    logic [31:0] mmem [NumDut][Words];
    int          wait_cnt [NumDut];

    // Transaction-level view of a grant: decide the response and update the model memory.
    task automatic model_grant(input int d);
        longint a;
        bit     inr;
        bit     bad_intg;
        int     idx;
        rsp_t   r;
        a        = longint'(addr[d]);
        inr      = (a >= longint'(Base)) && (a < longint'(Base) + 4 * Words);
        bad_intg = 1'b0;
`ifdef IBEX_MEM_WINTG_CHECK_EN
        bad_intg = we[d] && (wintg[d] != enc(wdata[d]));
`endif
        idx    = inr ? int'((a - longint'(Base)) / 4) : 0;
        r.dut  = d;
        r.due  = cyc + RL[d];
        r.err  = !inr || bad_intg;
        r.data = (!we[d] && inr) ? mmem[d][idx] : 32'h0;
        exp_q.push_back(r);
        if (we[d] && inr && !bad_intg) begin
            for (int k = 0; k < 4; k++) begin
                if (be[d][k]) mmem[d][idx][8*k +: 8] = wdata[d][8*k +: 8];
            end
        end
    endtask

    // Single compare process: every cycle, every instance.
    always @(negedge clk) begin
        for (int d = 0; d < NumDut; d++) begin
            if (!rst_n[d]) begin
                for (int i = exp_q.size() - 1; i >= 0; i--) if (exp_q[i].dut == d) exp_q.delete(i);
                wait_cnt[d] = 0;
                check(nm("rst_gnt", d),    32'(gnt[d]),    32'h0);
                check(nm("rst_rvalid", d), 32'(rvalid[d]), 32'h0);
                check(nm("rst_err", d),    32'(err[d]),    32'h0);
                check(nm("rst_rdata", d),  rdata[d],       32'h0);
                check(nm("rst_rintg", d),  32'(rintg[d]),  32'h2A);
            end else begin
                bit exp_gnt;
                int hit;
                exp_gnt = req[d] && (wait_cnt[d] == GD[d]);
                check(nm("gnt", d), 32'(gnt[d]), 32'(exp_gnt));
                wait_cnt[d] = (req[d] && !exp_gnt) ? wait_cnt[d] + 1 : 0;
                hit = -1;
                for (int i = 0; i < exp_q.size(); i++) begin
                    if (exp_q[i].dut == d && exp_q[i].due == cyc) begin
                        hit = i;
                        break;
                    end
                end
                check(nm("rvalid", d), 32'(rvalid[d]), 32'(hit >= 0));
                if (hit >= 0) begin
                    check(nm("err", d),   32'(err[d]),   32'(exp_q[hit].err));
                    check(nm("rdata", d), rdata[d],      exp_q[hit].data);
                    check(nm("rintg", d), 32'(rintg[d]), 32'(enc(exp_q[hit].data)));
                    exp_q.delete(hit);
                end
                if (exp_gnt) model_grant(d);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input int d, input logic [31:0] a, input logic w, input logic [3:0] b,
                                  input logic [31:0] wd, input logic [6:0] wi, output int gcyc);
        req[d]   = 1'b1;
        addr[d]  = a;
        we[d]    = w;
        be[d]    = b;
        wdata[d] = wd;
        wintg[d] = wi;
        gcyc     = -1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (gnt[d]) begin
                gcyc = cyc;
                break;
            end
        end
        if (gcyc < 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL %s: got no grant expected grant within 16 cycles", nm("gnt_timeout", d));
        end
        @(posedge clk);
        #1;
        req[d] = 1'b0;
    endtask

    task automatic check_output(input int d, input logic exp_err, input logic [31:0] exp_data, output int vcyc);
        vcyc = -1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (rvalid[d]) begin
                vcyc = cyc;
                break;
            end
        end
        check(nm("dir_rvalid_seen", d), 32'(vcyc >= 0), 32'h1);
        check(nm("dir_err", d),   32'(err[d]), 32'(exp_err));
        check(nm("dir_rdata", d), rdata[d],    exp_data);
        @(posedge clk);
        #1;
    endtask

    task automatic run_random(input int d, input int n);
        logic [31:0] a, wd;
        logic        w;
        logic [3:0]  b;
        int          gc;
        for (int t = 0; t < n; t++) begin
            if ($urandom_range(0, 9) < 8) begin
                a = Base + 32'($urandom_range(0, Words - 1)) * 4 + 32'($urandom_range(0, 3));
            end else begin
                case ($urandom_range(0, 3))
                    0:       a = Base - 32'd4;
                    1:       a = Base - 32'd1;
                    2:       a = Base + 32'(4 * Words);
                    default: a = $urandom();
                endcase
            end
            w  = 1'($urandom_range(0, 1));
            b  = 4'($urandom_range(0, 15));
            wd = $urandom();
            apply_stimulus(d, a, w, b, wd, enc(wd), gc);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
        end
    endtask

    initial begin
        int gc, vc, s, late_rvalids;
        for (int d = 0; d < NumDut; d++) begin
            rst_n[d]    = 1'b0;
            req[d]      = 1'b0;
            addr[d]     = Base;
            we[d]       = 1'b0;
            be[d]       = 4'h0;
            wdata[d]    = 32'h0;
            wintg[d]    = enc(32'h0);
            wait_cnt[d] = 0;
        end
        idle(3);
        for (int d = 0; d < NumDut; d++) rst_n[d] = 1'b1;
        idle(1);

        check("enc_of_zero", 32'(enc(32'h0)), 32'h2A);
        check("enc_of_one",  32'(enc(32'h1)), 32'h33);

        for (int d = 0; d < NumDut; d++) begin
            for (int w = 0; w < Words; w++) begin
                logic [31:0] v;
                v = $urandom();
                apply_stimulus(d, Base + 32'(4 * w), 1'b1, 4'hF, v, enc(v), gc);
            end
        end
        idle(4);

        $display("[TB] directed: zero grant delay, latency 1");
        apply_stimulus(0, 32'h0010_0010, 1'b1, 4'hF, 32'hDEAD_BEEF, enc(32'hDEAD_BEEF), gc);
        s = cyc;
        apply_stimulus(0, 32'h0010_0010, 1'b0, 4'hF, 32'h0, enc(32'h0), gc);
        check("d0_gnt_same_cycle", 32'(gc - s), 32'd0);
        check_output(0, 1'b0, 32'hDEAD_BEEF, vc);
        check("d0_rvalid_latency", 32'(vc - gc), 32'd1);

        apply_stimulus(0, 32'h0010_0020, 1'b1, 4'hF, 32'hAABB_CCDD, enc(32'hAABB_CCDD), gc);
        apply_stimulus(0, 32'h0010_0020, 1'b1, 4'b0101, 32'h1122_3344, enc(32'h1122_3344), gc);
        apply_stimulus(0, 32'h0010_0020, 1'b0, 4'hF, 32'h0, enc(32'h0), gc);
        check_output(0, 1'b0, 32'hAA22_CC44, vc);

        apply_stimulus(0, 32'h0010_4000, 1'b0, 4'hF, 32'h0, enc(32'h0), gc);
        check_output(0, 1'b1, 32'h0, vc);
        apply_stimulus(0, 32'h000F_FFFC, 1'b0, 4'hF, 32'h0, enc(32'h0), gc);
        check_output(0, 1'b1, 32'h0, vc);
        apply_stimulus(0, 32'h0010_0010, 1'b0, 4'hF, 32'h0, enc(32'h0), gc);
        check_output(0, 1'b0, 32'hDEAD_BEEF, vc);

        for (int i = 0; i < 4; i++) begin
            apply_stimulus(0, Base + 32'(16 * i), 1'b0, 4'hF, 32'h0, enc(32'h0), gc);
        end
        idle(4);

        $display("[TB] directed: grant delay 3, latency 2");
        apply_stimulus(1, 32'h0010_0010, 1'b1, 4'hF, 32'h5A5A_0001, enc(32'h5A5A_0001), gc);
        idle(3);
        s = cyc;
        apply_stimulus(1, 32'h0010_0010, 1'b0, 4'hF, 32'h0, enc(32'h0), gc);
        check("d1_gnt_cycle", 32'(gc - s), 32'd3);
        check_output(1, 1'b0, 32'h5A5A_0001, vc);
        check("d1_rvalid_cycle", 32'(vc - s), 32'd5);

        $display("[TB] directed: reset with a response in flight, latency 3");
        apply_stimulus(2, 32'h0010_0024, 1'b1, 4'hF, 32'hCAFE_F00D, enc(32'hCAFE_F00D), gc);
        idle(4);
        apply_stimulus(2, 32'h0010_0024, 1'b0, 4'hF, 32'h0, enc(32'h0), gc);
        rst_n[2] = 1'b0;
        idle(1);
        rst_n[2] = 1'b1;
        late_rvalids = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rvalid[2]) late_rvalids++;
        end
        check("d2_no_rvalid_after_reset", 32'(late_rvalids), 32'd0);
        idle(1);
        apply_stimulus(2, 32'h0010_0024, 1'b0, 4'hF, 32'h0, enc(32'h0), gc);
        check_output(2, 1'b0, 32'hCAFE_F00D, vc);

        $display("[TB] randomized traffic");
        for (int d = 0; d < NumDut; d++) begin
            run_random(d, 120);
            idle(6);
        end

`ifdef IBEX_MEM_WINTG_CHECK_EN
        $display("[TB] directed: write integrity mismatch");
        begin
            logic [31:0] keep;
            keep = mmem[0][7];
            apply_stimulus(0, 32'h0010_001C, 1'b1, 4'hF, 32'h0BAD_F00D, enc(32'h0BAD_F00D) ^ 7'h01, gc);
            check_output(0, 1'b1, 32'h0, vc);
            apply_stimulus(0, 32'h0010_001C, 1'b0, 4'hF, 32'h0, enc(32'h0), gc);
            check_output(0, 1'b0, keep, vc);
            check("d0_intg_err_cnt", 32'(dut0.intg_err_cnt), 32'd1);
        end
`endif

        idle(8);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
